// File: rtl/frog_game_pkg.sv
// Shared definitions for the frog game: turn-state encodings used by the LED
// decoder and the geometry/score constants used by the renderer.
package frog_game_pkg;

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } game_state_t;

    localparam int LANES         = 6;
    localparam int LANE_PITCH    = 60;
    localparam int HOME_Y        = 420;
    localparam int PLAYER_HALF_W = 30;
    localparam int BLOCK_W       = 20;
    localparam int WIN_SCORE     = 10;

endpackage

// File: rtl/frog_game_ctrl_btn_move_latch.sv
// One button's move request: two-flop synchroniser, rising-edge detect and a
// pending-move flag that is held until the next clear (game tick or idle).
module btn_move_latch (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic clear,
    output logic pending
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic pending_reg;
    logic rise;

    assign rise    = sync2_reg & ~prev_reg;
    assign pending = pending_reg;

    // Bring the button level into the clock domain and keep one delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    // Remember a press until the move logic consumes it on a tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg <= 1'b0;
        end else if (clear) begin
            pending_reg <= 1'b0;
        end else if (rise) begin
            pending_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/frog_game_ctrl.sv
// Frog game controller: player row, lane collision checks, turn FSM and scores.
// Build option: define GAME_TWO_PLAYER_EN for two-player turn alternation and a
// live p2_score; otherwise a single player stays in QGAME_1 and p2_score is 0.
module frog_game_ctrl #(
    parameter int LANES         = frog_game_pkg::LANES,
    parameter int LANE_PITCH    = frog_game_pkg::LANE_PITCH,
    parameter int HOME_Y        = frog_game_pkg::HOME_Y,
    parameter int PLAYER_HALF_W = frog_game_pkg::PLAYER_HALF_W,
    parameter int BLOCK_W       = frog_game_pkg::BLOCK_W,
    parameter int WIN_SCORE     = frog_game_pkg::WIN_SCORE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  tick,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic [9:0]            player_x,
    input  logic [LANES*10-1:0]   block_x,
    output logic [9:0]            player_y,
    output logic [1:0]            state,
    output logic [3:0]            p1_score,
    output logic [3:0]            p2_score,
    output logic                  hit
);
    import frog_game_pkg::*;

    localparam logic [9:0] PITCH_Y = 10'(LANE_PITCH);
    localparam logic [9:0] HOME_V  = 10'(HOME_Y);
    localparam logic [3:0] WIN_V   = 4'(WIN_SCORE);

    game_state_t state_reg, state_next;
    logic [9:0]  player_y_reg, player_y_next;
    logic [3:0]  p1_score_reg, p1_score_next;
    logic [3:0]  p2_score_reg, p2_score_next;
    logic        hit_reg, hit_next;
    logic        eval_reg, eval_next;

    logic        up_pending, down_pending, move_clear;
    logic [9:0]  moved_y;
    logic [10:0] down_sum;
    logic [3:0]  score_inc;
    logic [11:0] px_wide;
    logic [LANES-1:0] lane_hit;

    // Pending flags are consumed by every tick and kept empty while idle.
    assign move_clear = tick | (state_reg == QI);

    btn_move_latch u_up (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn_up),
        .clear   (move_clear),
        .pending (up_pending)
    );

    btn_move_latch u_down (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn_down),
        .clear   (move_clear),
        .pending (down_pending)
    );

    // Widened to 12 bits so block_x + widths and player_x + half width never wrap.
    assign px_wide = {2'b00, player_x};

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [11:0] bx_wide;
            assign bx_wide      = {2'b00, block_x[10*gi +: 10]};
            assign lane_hit[gi] = (player_y_reg == 10'((gi + 1) * LANE_PITCH))
                                && (bx_wide + 12'(BLOCK_W + PLAYER_HALF_W) > px_wide)
                                && (bx_wide < px_wide + 12'(PLAYER_HALF_W));
        end
    endgenerate

    assign down_sum  = {1'b0, player_y_reg} + {1'b0, PITCH_Y};
    assign score_inc = ((state_reg == QGAME_2) ? p2_score_reg : p1_score_reg) + 4'd1;

    // One-lane move; opposing requests cancel, row clamps at 0 and HOME_Y.
    always_comb begin
        moved_y = player_y_reg;
        if (up_pending && !down_pending) begin
            moved_y = (player_y_reg >= PITCH_Y) ? (player_y_reg - PITCH_Y) : 10'd0;
        end else if (down_pending && !up_pending) begin
            moved_y = (down_sum > {1'b0, HOME_V}) ? HOME_V : down_sum[9:0];
        end
    end

    // Turn FSM next state plus player row, scores and hit pulse.
    always_comb begin
        state_next    = state_reg;
        player_y_next = player_y_reg;
        p1_score_next = p1_score_reg;
        p2_score_next = p2_score_reg;
        hit_next      = 1'b0;
        eval_next     = 1'b0;
        case (state_reg)
            QI: begin
                if (start) begin
                    state_next    = QGAME_1;
                    player_y_next = HOME_V;
                    p1_score_next = 4'd0;
                    p2_score_next = 4'd0;
                end
            end
            QGAME_1, QGAME_2: begin
                if (tick) begin
                    eval_next     = 1'b1;
                    player_y_next = moved_y;
                end
                // Evaluation of the row latched by the previous tick; a reset to home wins over a new move.
                if (eval_reg) begin
                    if (player_y_reg == 10'd0) begin
                        player_y_next = HOME_V;
                        if (state_reg == QGAME_2) begin
                            p2_score_next = score_inc;
                        end else begin
                            p1_score_next = score_inc;
                        end
                        if (score_inc == WIN_V) begin
                            state_next = QDONE;
                        end
                    end else if (|lane_hit) begin
                        hit_next      = 1'b1;
                        player_y_next = HOME_V;
`ifdef GAME_TWO_PLAYER_EN
                        state_next    = (state_reg == QGAME_1) ? QGAME_2 : QGAME_1;
`endif
                    end
                end
            end
            default: begin
                // QDONE: everything holds until reset.
            end
        endcase
    end

    // Turn state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= QI;
        end else begin
            state_reg <= state_next;
        end
    end

    // Player row, scores, evaluation strobe and hit pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            player_y_reg <= HOME_V;
            p1_score_reg <= 4'd0;
            p2_score_reg <= 4'd0;
            hit_reg      <= 1'b0;
            eval_reg     <= 1'b0;
        end else begin
            player_y_reg <= player_y_next;
            p1_score_reg <= p1_score_next;
            p2_score_reg <= p2_score_next;
            hit_reg      <= hit_next;
            eval_reg     <= eval_next;
        end
    end

    assign player_y = player_y_reg;
    assign state    = state_reg;
    assign p1_score = p1_score_reg;
    assign hit      = hit_reg;
`ifdef GAME_TWO_PLAYER_EN
    assign p2_score = p2_score_reg;
`else
    assign p2_score = 4'd0;
`endif

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Self-checking bench for frog_game_ctrl: directed scenarios followed by random
// rounds (press, tick, evaluate) compared against a row/score/turn model.
module tb_frog_game_ctrl;

    localparam int NL = 6;
`ifdef GAME_TWO_PLAYER_EN
    localparam bit TWO_P = 1'b1;
`else
    localparam bit TWO_P = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            tick;
    logic            btn_up;
    logic            btn_down;
    logic [9:0]      player_x;
    logic [NL*10-1:0] block_x;
    logic [9:0]      player_y;
    logic [1:0]      state;
    logic [3:0]      p1_score;
    logic [3:0]      p2_score;
    logic            hit;

    int checks   = 0;
    int failures = 0;

    // Reference model: game phase 0=idle 1=player1 2=player2 3=done.
    int m_state, m_y, m_p1, m_p2;
    int lane_bx[NL];

    always #5 clk = ~clk;

    frog_game_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .tick     (tick),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .player_x (player_x),
        .block_x  (block_x),
        .player_y (player_y),
        .state    (state),
        .p1_score (p1_score),
        .p2_score (p2_score),
        .hit      (hit)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_blocks();
        for (int i = 0; i < NL; i++) begin
            block_x[10*i +: 10] = 10'(lane_bx[i]);
        end
    endtask

    task automatic set_all_blocks(input int v);
        for (int i = 0; i < NL; i++) lane_bx[i] = v;
        load_blocks();
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_y"},     int'(player_y), m_y);
        check({tag, "_state"}, int'(state),    m_state);
        check({tag, "_p1"},    int'(p1_score), m_p1);
        check({tag, "_p2"},    int'(p2_score), m_p2);
    endtask

    // op: 0 none, 1 up, 2 down, 3 both. Press long enough for the edge to land, release, then tick.
    task automatic do_round(input int op, input string name);
        int y_moved;
        int ln;
        int exp_hit;
        btn_up   = (op == 1) || (op == 3);
        btn_down = (op == 2) || (op == 3);
        repeat (4) @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (4) @(negedge clk);

        exp_hit = 0;
        if (m_state == 1 || m_state == 2) begin
            if (op == 1)      m_y = (m_y >= 60) ? m_y - 60 : 0;
            else if (op == 2) m_y = (m_y + 60 > 420) ? 420 : m_y + 60;
        end
        y_moved = m_y;
        if (m_state == 1 || m_state == 2) begin
            if (m_y == 0) begin
                if (m_state == 1) m_p1++;
                else              m_p2++;
                m_y = 420;
                if (m_p1 == 10 || m_p2 == 10) m_state = 3;
            end else if (m_y % 60 == 0 && m_y >= 60 && m_y <= 60 * NL) begin
                ln = m_y / 60 - 1;
                if (lane_bx[ln] + 50 > int'(player_x) && lane_bx[ln] < int'(player_x) + 30) begin
                    exp_hit = 1;
                    m_y     = 420;
                    if (TWO_P) m_state = 3 - m_state;
                end
            end
        end

        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check({name, "_moved_y"}, int'(player_y), y_moved);
        @(negedge clk);
        check({name, "_hit"}, int'(hit), exp_hit);
        check_outputs(name);
        @(negedge clk);
        check({name, "_hit_clear"}, int'(hit), 0);
        $display("round %s op=%0d x=%0d y=%0d hit=%0d state=%0d p1=%0d p2=%0d",
                 name, op, player_x, player_y, exp_hit, state, p1_score, p2_score);
    endtask

    initial begin
        int r;
        int op;
        int v;
        reset    = 1'b1;
        start    = 1'b0;
        tick     = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        player_x = 10'd320;
        set_all_blocks(600);
        m_state = 0; m_y = 420; m_p1 = 0; m_p2 = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_hit", int'(hit), 0);
        check_outputs("rst");

        // Ticks and presses are ignored while idle.
        do_round(1, "idle_tick");

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_state = 1; m_y = 420; m_p1 = 0; m_p2 = 0;
        check_outputs("start");

        do_round(2, "down_at_home");
        do_round(1, "up_clear");
        do_round(3, "both_buttons");
        do_round(2, "down_back");

        // Lane 5 boundary: block starting exactly at player_x+30 does not touch.
        lane_bx[5] = 350; load_blocks();
        do_round(1, "edge_no_hit");
        do_round(2, "down_again");
        // Block at x=0 with the player near the left edge: no wrap in the compare.
        lane_bx[5] = 0; player_x = 10'd10; load_blocks();
        do_round(1, "edge_hit_x0");
        lane_bx[5] = 300; player_x = 10'd320; load_blocks();
        do_round(1, "hit_p2");

        // Clear lanes and climb to the goal.
        set_all_blocks(600);
        for (int i = 0; i < 7; i++) do_round(1, "climb");

        // Random rounds.
        for (r = 0; r < 120; r++) begin
            player_x = 10'($urandom_range(0, 639));
            for (int i = 0; i < NL; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    v = int'(player_x) + int'($urandom_range(0, 100)) - 60;
                    lane_bx[i] = (v < 0) ? 0 : v;
                end else begin
                    lane_bx[i] = int'($urandom_range(0, 1023));
                end
            end
            load_blocks();
            v  = int'($urandom_range(0, 9));
            op = (v < 6) ? 1 : (v < 8) ? 2 : (v == 8) ? 3 : 0;
            do_round(op, "random");
        end

        // No blocks in reach: climb until someone wins.
        set_all_blocks(1000);
        for (r = 0; r < 160 && m_state != 3; r++) do_round(1, "to_done");
        check("reached_done", int'(state), 3);

        // Done state ignores further ticks and presses.
        do_round(1, "done_up");
        do_round(2, "done_down");

        // Reset between clock edges must clear outputs without waiting for a clock.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        m_state = 0; m_y = 420; m_p1 = 0; m_p2 = 0;
        check("async_rst_hit", int'(hit), 0);
        check_outputs("async_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_round(1, "post_reset_tick");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
